// File: rtl/mc_datapath.sv
// rtl/mc_datapath.sv - multi-cycle CPU datapath with sequencer FSM and req/ack memory port
module mc_datapath #(
    parameter int            DW       = 16,
    parameter int            AW       = 16,
    parameter int            NREG     = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          halted,
    output logic          illegal,
    output logic [2:0]    flags,
    output logic [AW-1:0] dbg_pc,
    output logic [DW-1:0] dbg_ir
);
    localparam int RW = $clog2(NREG);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [3:0] OP_ALU  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_BEQZ = 4'b0100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    logic [2:0]    state;
    logic [AW-1:0] pc;
    logic [AW-1:0] mar;
    logic [DW-1:0] ir;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] result;
    logic [2:0]    flag_q;
    logic [DW-1:0] regs [NREG];

    logic [3:0]    op;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs;
    logic [DW-1:0] imm_ext;
    logic [2:0]    funct;
    logic          op_defined;

    assign op      = ir[DW-1 -: 4];
    assign rd      = ir[DW-5 -: RW];
    assign rs      = ir[DW-5-RW -: RW];
    assign imm_ext = {{(DW-8){ir[7]}}, ir[7:0]};
    assign funct   = ir[2:0];

    assign op_defined = (op == OP_ALU) || (op == OP_ADDI) || (op == OP_LD) ||
                        (op == OP_ST)  || (op == OP_BEQZ) || (op == OP_HALT);

    logic [DW:0]   sum;
    logic [DW-1:0] alu_res;
    logic          alu_c;

    // One extra bit on the adder gives carry for ADD and borrow for SUB.
    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        if (op == OP_ADDI) begin
            sum     = {1'b0, a} + {1'b0, imm_ext};
            alu_res = sum[DW-1:0];
            alu_c   = sum[DW];
        end else begin
            case (funct)
                3'b000: begin
                    sum     = {1'b0, a} + {1'b0, b};
                    alu_res = sum[DW-1:0];
                    alu_c   = sum[DW];
                end
                3'b001: begin
                    sum     = {1'b0, a} - {1'b0, b};
                    alu_res = sum[DW-1:0];
                    alu_c   = sum[DW];
                end
                3'b010: alu_res = a & b;
                3'b011: alu_res = a | b;
                3'b100: alu_res = a ^ b;
                3'b101: alu_res = ~b;
                3'b110: begin
                    alu_res = {b[DW-2:0], 1'b0};
                    alu_c   = b[DW-1];
                end
                default: begin
                    alu_res = {1'b0, b[DW-1:1]};
                    alu_c   = b[0];
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            mar    <= '0;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            result <= '0;
            flag_q <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        pc    <= pc + AW'(1);
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a     <= regs[rd];
                    b     <= regs[rs];
                    mar   <= regs[rs][AW-1:0];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    case (op)
                        OP_ALU, OP_ADDI: begin
                            result <= alu_res;
                            flag_q <= {alu_res[DW-1], alu_c, alu_res == '0};
                            state  <= S_WB;
                        end
                        OP_LD, OP_ST: state <= S_MEM;
                        OP_BEQZ: begin
                            if (a == '0) pc <= pc + imm_ext[AW-1:0];
                            state <= S_WB;
                        end
                        OP_HALT: state <= S_HALT;
                        default: state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (op == OP_LD) regs[rd] <= mem_rdata;
                        state <= S_FETCH;
                    end
                end
                S_WB: begin
                    if (op == OP_ALU || op == OP_ADDI) regs[rd] <= result;
                    state <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Port outputs decode straight from state so an async reset drops mem_req at once.
    assign mem_req   = (state == S_FETCH) || (state == S_MEM);
    assign mem_we    = (state == S_MEM) && (op == OP_ST);
    assign mem_addr  = (state == S_FETCH) ? pc : (state == S_MEM) ? mar : '0;
    assign mem_wdata = mem_we ? a : '0;
    assign halted    = (state == S_HALT);
    assign illegal   = (state == S_EXEC) && !op_defined;
    assign flags     = flag_q;
    assign dbg_pc    = pc;
    assign dbg_ir    = ir;
endmodule

// File: tb/tb_mc_datapath.sv
// tb/tb_mc_datapath.sv - directed and random programs against an instruction-level reference model
module tb_mc_datapath;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int NREG = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          halted;
    logic          illegal;
    logic [2:0]    flags;
    logic [AW-1:0] dbg_pc;
    logic [DW-1:0] dbg_ir;

    always #5 clk = ~clk;

    mc_datapath #(.DW(DW), .AW(AW), .NREG(NREG), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .halted(halted), .illegal(illegal), .flags(flags),
        .dbg_pc(dbg_pc), .dbg_ir(dbg_ir)
    );

    int nchecks = 0;
    int nerrors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [15:0] mem [0:65535];
    logic [15:0] mm  [0:65535];

    int          ack_delay = 0;
    int          wait_cnt = 0;
    bit          prev_pend = 0;
    bit          prev_ill = 0;
    logic [15:0] p_addr, p_wdata;
    logic        p_we;
    int          ill_cnt = 0;
    int          st_cyc = 0;
    bit          seen8 = 0;
    logic [15:0] last_rd = '0;

    // Memory responder plus handshake/pulse monitors, all evaluated away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            mem_ack   = 1'b0;
            wait_cnt  = 0;
            prev_pend = 0;
            prev_ill  = 0;
        end else begin
            if (mem_req && prev_pend) begin
                check("hold_addr", mem_addr, p_addr);
                check("hold_we", mem_we, p_we);
                check("hold_wdata", mem_wdata, p_wdata);
            end
            if (illegal) begin
                ill_cnt++;
                check("illegal_width", prev_ill, 0);
            end
            prev_ill = illegal;
            if (mem_req && mem_we) st_cyc++;
            if (mem_req && !mem_we) begin
                last_rd = mem_addr;
                if (mem_addr == 16'd8) seen8 = 1;
            end
            if (mem_req && wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                if (mem_we) mem[mem_addr] = mem_wdata;
                wait_cnt  = 0;
            end else if (mem_req) begin
                mem_ack = 1'b0;
                wait_cnt++;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
            prev_pend = mem_req && !mem_ack;
            p_addr    = mem_addr;
            p_we      = mem_we;
            p_wdata   = mem_wdata;
        end
    end

    int m_regs [4];
    int m_flags, m_pc, m_ir, m_steps, m_acc, m_ill;
    bit m_halt;

    // Instruction-set interpreter over the mm copy of memory.
    task automatic model_run();
        int ir, op, rd, rs, imm, a, b, res, c, s;
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_flags = 0; m_pc = 0; m_ir = 0; m_steps = 0; m_acc = 0; m_ill = 0; m_halt = 0;
        while (!m_halt && m_steps < 300) begin
            ir = int'(mm[m_pc]);
            m_ir = ir;
            m_pc = (m_pc + 1) % 65536;
            m_acc++;
            op = ir >> 12; rd = (ir >> 10) & 3; rs = (ir >> 8) & 3;
            imm = ir & 255;
            if (imm >= 128) imm -= 256;
            a = m_regs[rd]; b = m_regs[rs];
            res = -1; c = 0;
            case (op)
                0: case (ir & 7)
                       0: begin s = a + b; res = s & 65535; c = s >> 16; end
                       1: begin res = (a - b) & 65535; c = (a < b); end
                       2: res = a & b;
                       3: res = a | b;
                       4: res = a ^ b;
                       5: res = (~b) & 65535;
                       6: begin res = (b << 1) & 65535; c = b >> 15; end
                       default: begin res = b >> 1; c = b & 1; end
                   endcase
                1: begin s = a + (imm & 65535); res = s & 65535; c = s >> 16; end
                2: begin m_regs[rd] = int'(mm[b]); m_acc++; end
                3: begin mm[b] = a[15:0]; m_acc++; end
                4: if (a == 0) m_pc = (m_pc + imm) & 65535;
                15: m_halt = 1;
                default: m_ill++;
            endcase
            if (res >= 0) begin
                m_regs[rd] = res;
                m_flags = ((res >> 15) << 2) | (c << 1) | (res == 0 ? 1 : 0);
            end
            if (!m_halt) m_steps++;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen8 = 0;
    endtask

    task automatic load(input logic [15:0] prog [$], input bit rnd_fill);
        for (int i = 0; i < 65536; i++) mem[i] = rnd_fill ? 16'($urandom) : 16'hF000;
        foreach (prog[i]) mem[i] = prog[i];
        for (int i = 0; i < 5; i++) mem[prog.size() + i] = 16'hF000;
    endtask

    task automatic run_prog(input string name, input bit do_reset);
        int cyc, diffs;
        for (int i = 0; i < 65536; i++) mm[i] = mem[i];
        model_run();
        if (do_reset) apply_reset();
        ill_cnt = 0;
        st_cyc = 0;
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        while (cyc < 5000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (halted) break;
        end
        check($sformatf("%s_halted", name), halted, 1);
        check($sformatf("%s_cycles", name), cyc, 4 * m_steps + 4 + ack_delay * m_acc);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_r%0d", name, i), dut.regs[i], m_regs[i]);
        check($sformatf("%s_flags", name), flags, m_flags);
        check($sformatf("%s_pc", name), dbg_pc, m_pc);
        check($sformatf("%s_ir", name), dbg_ir, m_ir);
        check($sformatf("%s_illegal", name), ill_cnt, m_ill);
        diffs = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== mm[i]) diffs++;
        check($sformatf("%s_mem", name), diffs, 0);
    endtask

    logic [15:0] prog [$];

    initial begin
        apply_reset();
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal, 0);
        check("rst_flags", flags, 0);
        check("rst_pc", dbg_pc, 0);
        check("rst_ir", dbg_ir, 0);

        ack_delay = 0;
        prog = '{16'h1405, 16'h18FE, 16'h0600, 16'hF000};
        load(prog, 0);
        run_prog("t1", 1);
        check("t1_r1_const", dut.regs[1], 16'h0003);
        check("t1_flags_const", flags, 3'b010);

        prog = '{16'h1401, 16'h0501, 16'hF000};
        load(prog, 0);
        run_prog("t2a", 1);
        check("t2a_flags_const", flags, 3'b001);

        prog = '{16'h1C40, 16'h2B00, 16'h0607, 16'hF000};
        load(prog, 0);
        mem[16'h40] = 16'h8001;
        run_prog("t2b", 1);
        check("t2b_r1_const", dut.regs[1], 16'h4000);
        check("t2b_flags_const", flags, 3'b010);

        ack_delay = 3;
        prog = '{16'h1820, 16'h1C41, 16'h2700, 16'h3600, 16'h2E00, 16'hF000};
        load(prog, 0);
        mem[16'h41] = 16'hBEEF;
        run_prog("t3", 1);
        check("t3_store_word", mem[16'h20], 16'hBEEF);
        check("t3_r3_const", dut.regs[3], 16'hBEEF);
        check("t3_st_req_cycles", st_cyc, 4);
        ack_delay = 0;

        prog = '{16'h1400, 16'h1400, 16'h1400, 16'h1400, 16'h1400, 16'h1400, 16'h1400, 16'h40FF};
        load(prog, 0);
        apply_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (120) @(negedge clk);
        check("t4_loop_not_halted", halted, 0);
        check("t4_no_fetch_8", seen8, 0);
        check("t4_last_fetch", last_rd, 7);

        prog = '{16'h1001, 16'h1400, 16'h1400, 16'h1400, 16'h1400, 16'h1400, 16'h1400, 16'h40FF};
        load(prog, 0);
        run_prog("t4b", 1);
        check("t4b_pc_const", dbg_pc, 9);

        prog = '{16'h5000, 16'hF000};
        load(prog, 0);
        run_prog("t5", 1);
        check("t5_ill_const", ill_cnt, 1);
        check("t5_pc_const", dbg_pc, 2);

        prog = '{16'h1405, 16'h18FE, 16'h0600, 16'hF000};
        load(prog, 0);
        apply_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        ack_delay = 1000;
        repeat (5) @(negedge clk);
        check("t6_req_waiting", mem_req, 1);
        check("t6_pc_before", dbg_pc, 3);
        check("t6_r1_before", dut.regs[1], 3);
        #2 rst = 1'b1;
        #1;
        check("t6_req_async", mem_req, 0);
        check("t6_pc_reset", dbg_pc, 0);
        check("t6_r1_reset", dut.regs[1], 0);
        check("t6_r2_reset", dut.regs[2], 0);
        @(negedge clk);
        rst = 1'b0;
        ack_delay = 0;
        run_prog("t6", 0);
        check("t6_r1_after", dut.regs[1], 3);

        for (int t = 0; t < 8; t++) begin
            ack_delay = t % 3;
            do begin
                prog.delete();
                for (int k = 0; k < 20; k++) begin
                    int sel;
                    logic [15:0] w;
                    sel = $urandom_range(0, 9);
                    w = 16'($urandom);
                    case (sel)
                        0, 1, 2: w[15:12] = 4'b0000;
                        3, 4:    w[15:12] = 4'b0001;
                        5:       w[15:12] = 4'b0010;
                        6:       w[15:12] = 4'b0011;
                        7:       begin w[15:12] = 4'b0100; w[7:0] = 8'($urandom_range(0, 3)); end
                        8:       w[15:12] = 4'($urandom_range(5, 14));
                        default: w[15:12] = 4'b0001;
                    endcase
                    prog.push_back(w);
                end
                prog.push_back(16'hF000);
                load(prog, 1);
                for (int i = 0; i < 65536; i++) mm[i] = mem[i];
                model_run();
            end while (!m_halt);
            run_prog($sformatf("rnd%0d", t), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
